// File: rtl/ptw_fetch_arbiter.sv
// rtl/ptw_fetch_arbiter.sv - round-robin PTE fetch engine serialising MMU channels onto one memory read port
module ptw_fetch_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_W     = 32,
    parameter int PTE_BYTES  = 4,
    parameter int BEAT_BYTES = 1,
    parameter int TIMEOUT    = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic                        flush,
    output logic [NUM_REQ-1:0]          resp_valid,
    output logic                        resp_err,
    output logic [PTE_BYTES*8-1:0]      resp_data,
    output logic                        busy,
    output logic                        mem_req,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic                        mem_rvalid,
    input  logic [BEAT_BYTES*8-1:0]     mem_rdata
);
    localparam int NBEATS = PTE_BYTES / BEAT_BYTES;
    localparam int PTE_W  = PTE_BYTES * 8;
    localparam int BEAT_W = BEAT_BYTES * 8;
    localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(NBEATS - 1);
    localparam logic [15:0]   TMO_LAST  = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_BEAT, S_DONE, S_DRAIN, S_HOLD} state_t;

    state_t            state;
    logic [IW-1:0]     grant;
    logic [IW-1:0]     rr_ptr;
    logic [CW-1:0]     beat;
    logic [15:0]       tmo;
    logic [PTE_W-1:0]  pte_buf;
    logic              err;
    logic [IW-1:0]     arb_idx;
    logic [IW-1:0]     cand;

    // Scan from farthest to nearest so the first valid channel after rr_ptr wins.
    always_comb begin
        arb_idx = rr_ptr;
        cand    = rr_ptr;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IW'((int'(rr_ptr) + k) % NUM_REQ);
            if (req_valid[cand]) begin
                arb_idx = cand;
            end
        end
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            grant      <= '0;
            rr_ptr     <= IW'(NUM_REQ - 1);
            beat       <= '0;
            tmo        <= '0;
            pte_buf    <= '0;
            err        <= 1'b0;
            resp_valid <= '0;
            resp_err   <= 1'b0;
            resp_data  <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
        end else begin
            resp_valid <= '0;
            resp_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if ((|req_valid) && !flush) begin
                        grant    <= arb_idx;
                        mem_addr <= req_addr[arb_idx*ADDR_W +: ADDR_W];
                        beat     <= '0;
                        tmo      <= '0;
                        pte_buf  <= '0;
                        err      <= 1'b0;
                        mem_req  <= 1'b1;
                        state    <= S_BEAT;
                    end
                end
                S_BEAT: begin
                    if (flush) begin
                        // A beat arriving with the flush is consumed, so nothing is left to drain.
                        mem_req <= 1'b0;
                        tmo     <= '0;
                        state   <= mem_rvalid ? S_IDLE : S_DRAIN;
                    end else if (mem_rvalid) begin
                        pte_buf[beat*BEAT_W +: BEAT_W] <= mem_rdata;
                        tmo <= '0;
                        if (beat == LAST_BEAT) begin
                            mem_req <= 1'b0;
                            state   <= S_DONE;
                        end else begin
                            beat     <= beat + CW'(1);
                            mem_addr <= mem_addr + ADDR_W'(BEAT_BYTES);
                        end
                    end else if (tmo == TMO_LAST) begin
                        pte_buf <= '0;
                        err     <= 1'b1;
                        mem_req <= 1'b0;
                        state   <= S_DONE;
                    end else begin
                        tmo <= tmo + 16'd1;
                    end
                end
                S_DONE: begin
                    resp_valid <= NUM_REQ'(1) << grant;
                    resp_data  <= pte_buf;
                    resp_err   <= err;
                    rr_ptr     <= grant;
                    state      <= S_HOLD;
                end
                S_HOLD: begin
                    state <= S_IDLE;
                end
                S_DRAIN: begin
                    if (mem_rvalid || (tmo == TMO_LAST)) begin
                        state <= S_IDLE;
                    end else begin
                        tmo <= tmo + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ptw_fetch_arbiter.sv
// tb/tb_ptw_fetch_arbiter.sv - randomized fetch timelines against a cycle-planned reference model
module tb_ptw_fetch_arbiter;
    localparam int TMO  = 8;
    localparam int MAXC = 4000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req_valid;
    logic [63:0] req_addr;
    logic        flush;
    logic [1:0]  resp_valid;
    logic        resp_err;
    logic [31:0] resp_data;
    logic        busy;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [7:0]  mem_rdata;

    logic [1:0]  w_req_valid;
    logic [63:0] w_req_addr;
    logic        w_flush;
    logic [1:0]  w_resp_valid;
    logic        w_resp_err;
    logic [63:0] w_resp_data;
    logic        w_busy;
    logic        w_mem_req;
    logic [31:0] w_mem_addr;
    logic        w_mem_rvalid;
    logic [31:0] w_mem_rdata;

    always #5 clk = ~clk;

    ptw_fetch_arbiter #(.NUM_REQ(2), .ADDR_W(32), .PTE_BYTES(4), .BEAT_BYTES(1), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .flush(flush),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_data(resp_data), .busy(busy),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    ptw_fetch_arbiter #(.NUM_REQ(2), .ADDR_W(32), .PTE_BYTES(8), .BEAT_BYTES(4), .TIMEOUT(TMO)) u_wide (
        .clk(clk), .rst(rst), .req_valid(w_req_valid), .req_addr(w_req_addr), .flush(w_flush),
        .resp_valid(w_resp_valid), .resp_err(w_resp_err), .resp_data(w_resp_data), .busy(w_busy),
        .mem_req(w_mem_req), .mem_addr(w_mem_addr), .mem_rvalid(w_mem_rvalid), .mem_rdata(w_mem_rdata)
    );

    // Planned stimulus and expected outputs, one entry per clock cycle.
    logic [1:0]  d_rv [MAXC];
    logic [63:0] d_ra [MAXC];
    bit          d_fl [MAXC];
    bit          d_mv [MAXC];
    logic [7:0]  d_md [MAXC];
    bit          e_mreq [MAXC];
    bit          e_busy [MAXC];
    logic [31:0] e_addr [MAXC];
    logic [1:0]  e_rv [MAXC];
    bit          e_err [MAXC];
    logic [31:0] e_data [MAXC];

    int          t;
    int          rr;
    bit [1:0]    pend;
    logic [31:0] paddr [2];

    bit [1:0]    p_new;
    logic [31:0] p_addr [2];
    logic [31:0] p_data;
    int          p_dly [4];
    int          p_fbeat;
    int          p_foff;
    int          p_late;
    bit          p_iflush;

    int n_tests = 0;
    int n_fail  = 0;
    int cur_c   = -1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=0x%0h want=0x%0h", nm, cur_c, act, exp);
        end
    endtask

    task automatic fill(input int c, input bit mreq, input bit bsy, input logic [31:0] addr, input int g);
        e_mreq[c] = mreq;
        e_busy[c] = bsy;
        e_addr[c] = addr;
        for (int i = 0; i < 2; i++) begin
            if (i == g) begin
                d_rv[c][i] = ($urandom_range(0, 3) != 0);
                d_ra[c][i*32 +: 32] = $urandom;
            end else begin
                d_rv[c][i] = pend[i];
                d_ra[c][i*32 +: 32] = pend[i] ? paddr[i] : $urandom;
            end
        end
    endtask

    task automatic clear_params();
        p_new = 2'b00;
        p_data = $urandom;
        for (int b = 0; b < 4; b++) p_dly[b] = 0;
        p_fbeat = -1;
        p_foff = 0;
        p_late = TMO;
        p_iflush = 1'b0;
    endtask

    task automatic rand_params();
        int r;
        p_new = 2'($urandom_range(0, 3));
        for (int i = 0; i < 2; i++) p_addr[i] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : $urandom;
        p_data = $urandom;
        for (int b = 0; b < 4; b++) begin
            r = int'($urandom_range(0, 15));
            p_dly[b] = (r < 8) ? 0 : (r < 14) ? r - 7 : (r == 14) ? TMO : TMO - 1;
        end
        p_fbeat = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
        p_foff = 0;
        if (p_fbeat >= 0) p_foff = int'($urandom_range(0, (p_dly[p_fbeat] < TMO) ? p_dly[p_fbeat] : TMO - 1));
        p_late = int'($urandom_range(0, TMO));
        p_iflush = ($urandom_range(0, 7) == 0);
    endtask

    // Lays out one whole fetch on the timeline starting at IDLE cycle t.
    task automatic plan_fetch();
        int g, c, k;
        logic [31:0] data;
        bit er, stop;
        for (int i = 0; i < 2; i++) begin
            if (p_new[i] && !pend[i]) begin
                pend[i] = 1'b1;
                paddr[i] = p_addr[i];
            end
        end
        if (pend == 2'b00) begin
            fill(t, 0, 0, 0, -1);
            t++;
            return;
        end
        if (p_iflush) begin
            fill(t, 0, 0, 0, -1);
            d_fl[t] = 1'b1;
            t++;
        end
        g = -1;
        for (int off = 2; off >= 1; off--) if (pend[(rr + off) % 2]) g = (rr + off) % 2;
        fill(t, 0, 0, 0, -1);
        data = 0;
        er = 1'b0;
        stop = 1'b0;
        c = t + 1;
        for (int b = 0; b < 4 && !stop; b++) begin
            for (k = 0; k < TMO; k++) begin
                fill(c, 1, 1, paddr[g] + b, g);
                if (k == p_dly[b]) begin
                    d_mv[c] = 1'b1;
                    d_md[c] = p_data[b*8 +: 8];
                end
                if (b == p_fbeat && k == p_foff) begin
                    d_fl[c] = 1'b1;
                    c++;
                    if (k != p_dly[b]) begin
                        for (int j = 0; j < TMO; j++) begin
                            fill(c, 0, 1, 0, g);
                            if (j == p_late) begin
                                d_mv[c] = 1'b1;
                                c++;
                                break;
                            end
                            c++;
                        end
                    end
                    t = c;
                    return;
                end
                if (k == p_dly[b]) begin
                    data[b*8 +: 8] = p_data[b*8 +: 8];
                    c++;
                    break;
                end
                if (k == TMO - 1) begin
                    er = 1'b1;
                    data = 0;
                    stop = 1'b1;
                    c++;
                    break;
                end
                c++;
            end
        end
        fill(c, 0, 1, 0, g);
        d_fl[c] = 1'($urandom_range(0, 1));
        pend[g] = 1'b0;
        fill(c + 1, 0, 1, 0, -1);
        d_fl[c + 1] = 1'($urandom_range(0, 1));
        e_rv[c + 1] = 2'(1 << g);
        e_err[c + 1] = er;
        e_data[c + 1] = data;
        rr = g;
        t = c + 2;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        req_valid = 0; req_addr = 0; flush = 0; mem_rvalid = 0; mem_rdata = 0;
        w_req_valid = 0; w_req_addr = 0; w_flush = 0; w_mem_rvalid = 0; w_mem_rdata = 0;

        for (int c = 0; c < MAXC; c++) begin
            d_rv[c] = 0; d_ra[c] = {$urandom, $urandom}; d_fl[c] = 0; d_mv[c] = 0; d_md[c] = 8'($urandom);
            e_mreq[c] = 0; e_busy[c] = 0; e_addr[c] = 0; e_rv[c] = 0; e_err[c] = 0; e_data[c] = 0;
        end
        t = 0; rr = 1; pend = 2'b00;

        clear_params(); p_new = 2'b01; p_addr[0] = 32'h0000_1000; p_data = 32'h4433_2211; plan_fetch();
        clear_params(); p_new = 2'b11; p_addr[0] = 32'h0000_1100; p_addr[1] = 32'h0000_2100; plan_fetch();
        clear_params(); p_new = 2'b10; p_addr[1] = 32'h0000_2200; plan_fetch();
        clear_params(); p_new = 2'b01; p_addr[0] = 32'h0000_1300; plan_fetch();
        clear_params(); p_dly[2] = TMO; plan_fetch();
        clear_params(); p_new = 2'b10; p_addr[1] = 32'h0000_8000; p_dly[1] = 5; p_fbeat = 1; p_foff = 0; p_late = 2; plan_fetch();
        clear_params(); p_data = 32'hCAFE_F00D; plan_fetch();
        while (t < MAXC - 64) begin
            rand_params();
            plan_fetch();
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_mem_req", 64'(mem_req), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_resp_valid", 64'(resp_valid), 64'(0));
        chk("reset_resp_data", 64'(resp_data), 64'(0));
        chk("reset_mem_addr", 64'(mem_addr), 64'(0));
        rst = 1'b1;

        for (int c = 0; c < t; c++) begin
            @(posedge clk);
            #1;
            req_valid = d_rv[c]; req_addr = d_ra[c]; flush = d_fl[c];
            mem_rvalid = d_mv[c]; mem_rdata = d_md[c];
            @(negedge clk);
            cur_c = c;
            chk("mem_req", 64'(mem_req), 64'(e_mreq[c]));
            chk("busy", 64'(busy), 64'(e_busy[c]));
            chk("resp_valid", 64'(resp_valid), 64'(e_rv[c]));
            chk("resp_err", 64'(resp_err), 64'(e_err[c]));
            if (e_mreq[c]) chk("mem_addr", 64'(mem_addr), 64'(e_addr[c]));
            if (e_rv[c] != 0) chk("resp_data", 64'(resp_data), 64'(e_data[c]));
            if (c == 4) chk("lit_addr_beat3", 64'(mem_addr), 64'h1003);
            if (c == 6) begin
                chk("lit_first_resp", 64'(resp_valid), 64'h1);
                chk("lit_first_data", 64'(resp_data), 64'h4433_2211);
            end
            if (c == 13) chk("lit_rr_ch1", 64'(resp_valid), 64'h2);
            if (c == 20) chk("lit_rr_ch0", 64'(resp_valid), 64'h1);
            if (c == 27) chk("lit_rr_ch1_again", 64'(resp_valid), 64'h2);
            if (c == 40) begin
                chk("lit_tmo_valid", 64'(resp_valid), 64'h1);
                chk("lit_tmo_err", 64'(resp_err), 64'h1);
                chk("lit_tmo_data", 64'(resp_data), 64'h0);
            end
            if (c == 44) begin
                chk("lit_drain_mem_req", 64'(mem_req), 64'h0);
                chk("lit_drain_busy", 64'(busy), 64'h1);
            end
            if (c == 48) chk("lit_after_flush_addr", 64'(mem_addr), 64'h8000);
            if (c == 53) begin
                chk("lit_after_flush_valid", 64'(resp_valid), 64'h2);
                chk("lit_after_flush_data", 64'(resp_data), 64'hCAFE_F00D);
            end
        end
        cur_c = -1;

        // Complete a ch0 fetch so the last grant is ch0, then start ch1 and reset mid-beat.
        @(posedge clk);
        #1;
        req_valid = 2'b01; req_addr = {32'h0, 32'h0000_3000}; flush = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 8'hA5;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (resp_valid != 0) begin
                seen = 1'b1;
                break;
            end
        end
        chk("dir_resp_seen", 64'(seen), 64'h1);
        if (seen) begin
            chk("dir_resp_valid", 64'(resp_valid), 64'h1);
            chk("dir_resp_data", 64'(resp_data), 64'hA5A5_A5A5);
        end
        @(posedge clk);
        #1;
        req_valid = 2'b10; req_addr = {32'h0000_4000, 32'h0}; mem_rvalid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_req) begin
                seen = 1'b1;
                break;
            end
        end
        chk("dir_ch1_req_seen", 64'(seen), 64'h1);
        chk("dir_ch1_addr", 64'(mem_addr), 64'h4000);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_mem_req", 64'(mem_req), 64'h0);
        chk("async_rst_busy", 64'(busy), 64'h0);
        chk("async_rst_resp_valid", 64'(resp_valid), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        req_valid = 2'b11; req_addr = {32'h0000_4000, 32'h0000_5000};
        @(negedge clk);
        chk("post_rst_mem_req", 64'(mem_req), 64'h1);
        chk("post_rst_grant_ch0", 64'(mem_addr), 64'h5000);
        req_valid = 2'b00;

        // Wide configuration: two 32-bit beats form one 64-bit PTE.
        @(negedge clk);
        w_req_valid = 2'b01; w_req_addr = {32'h0, 32'h0000_2000};
        @(negedge clk);
        chk("wide_beat0_req", 64'(w_mem_req), 64'h1);
        chk("wide_beat0_addr", 64'(w_mem_addr), 64'h2000);
        w_mem_rvalid = 1'b1; w_mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("wide_beat1_addr", 64'(w_mem_addr), 64'h2004);
        w_mem_rdata = 32'h0000_00CF;
        @(negedge clk);
        w_mem_rvalid = 1'b0;
        chk("wide_done_no_resp", 64'(w_resp_valid), 64'h0);
        @(negedge clk);
        chk("wide_resp_valid", 64'(w_resp_valid), 64'h1);
        chk("wide_resp_data", w_resp_data, 64'h0000_00CF_DEAD_BEEF);
        chk("wide_resp_err", 64'(w_resp_err), 64'h0);
        w_req_valid = 2'b00;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
